// File: rtl/mul_div_seq.sv
// Iterative 32-bit multiply/divide unit (MULTU, MULT, DIVU, DIV).
// Each operation takes a fixed 36 busy cycles. All arithmetic goes through
// one shared 32-bit carry-lookahead adder.

module FullAdder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  grpG;
  logic [7:0]  grpP;
  logic [8:0]  grpC;
  logic [32:0] c;

  // Two-level lookahead: 4-bit group generate/propagate, group carries chained across groups
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    grpG = '0;
    grpP = '0;
    grpC = '0;
    c    = '0;
    for (int k = 0; k < 8; k++) begin
      grpP[k] = &p[4*k +: 4];
      grpG[k] = g[4*k+3]
              | (p[4*k+3] & g[4*k+2])
              | (p[4*k+3] & p[4*k+2] & g[4*k+1])
              | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    grpC[0] = cin;
    for (int k = 0; k < 8; k++) begin
      grpC[k+1] = grpG[k] | (grpP[k] & grpC[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k] = grpC[k];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
    end
    c[32] = grpC[8];
    s     = p ^ c[31:0];
    cout  = c[32];
  end
endmodule

module mul_div_seq #(
  parameter int XLEN   = 32,
  parameter int ITER_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_zero
);

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, CALC, FIX_LO, FIX_HI} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   origA_q, origA_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mq_q, mq_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              signA_q, signA_d;
  logic              negRes_q, negRes_d;
  logic              negRem_q, negRem_d;
  logic              carry_q, carry_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;
  logic              divZero_q, divZero_d;

  logic [XLEN-1:0]   addA, addB, addSum;
  logic              addCin, addCout;
  logic              isSigned, isDiv;
  logic              signCur, fixHi;
  logic [XLEN-1:0]   remShift;

  FullAdder adder (
    .a    (addA),
    .b    (addB),
    .cin  (addCin),
    .s    (addSum),
    .cout (addCout)
  );

  assign isSigned = op_q[0];
  assign isDiv    = op_q[1];

  // Next-state and datapath: every state steers the one adder and captures its sum
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    origA_d   = origA_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    cnt_d     = cnt_q;
    signA_d   = signA_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    carry_d   = carry_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divZero_d = divZero_q;
    addA      = '0;
    addB      = '0;
    addCin    = 1'b0;
    signCur   = 1'b0;
    fixHi     = 1'b0;
    remShift  = '0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ABS_A;
            op_d    = op;
            a_d     = src_a;
            b_d     = src_b;
            origA_d = src_a;
          end
        end
        ABS_A: begin
          signCur  = isSigned & a_q[XLEN-1];
          addA     = signCur ? ~a_q : a_q;
          addCin   = signCur;
          a_d      = addSum;
          signA_d  = signCur;
          negRem_d = signCur;
          state_d  = ABS_B;
        end
        ABS_B: begin
          signCur  = isSigned & b_q[XLEN-1];
          addA     = signCur ? ~b_q : b_q;
          addCin   = signCur;
          b_d      = addSum;
          negRes_d = signA_q ^ signCur;
          acc_d    = '0;
          mq_d     = isDiv ? a_q : addSum;
          cnt_d    = '0;
          state_d  = CALC;
        end
        CALC: begin
          if (isDiv) begin
            remShift = {acc_q[XLEN-2:0], mq_q[XLEN-1]};
            addA     = remShift;
            addB     = ~b_q;
            addCin   = 1'b1;
            if (addCout || acc_q[XLEN-1]) begin
              acc_d = addSum;
              mq_d  = {mq_q[XLEN-2:0], 1'b1};
            end else begin
              acc_d = remShift;
              mq_d  = {mq_q[XLEN-2:0], 1'b0};
            end
          end else begin
            addA  = acc_q;
            addB  = mq_q[0] ? a_q : '0;
            acc_d = {addCout, addSum[XLEN-1:1]};
            mq_d  = {addSum[0], mq_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + ITER_W'(1);
          if (cnt_q == ITER_W'(XLEN-1)) begin
            state_d = FIX_LO;
          end
        end
        FIX_LO: begin
          addA    = negRes_q ? ~mq_q : mq_q;
          addCin  = negRes_q;
          mq_d    = addSum;
          carry_d = addCout;
          state_d = FIX_HI;
        end
        FIX_HI: begin
          fixHi   = isDiv ? negRem_q : negRes_q;
          addA    = fixHi ? ~acc_q : acc_q;
          addCin  = fixHi & (isDiv | carry_q);
          state_d = IDLE;
          done_d  = 1'b1;
          if (isDiv && (b_q == '0)) begin
            hi_d      = origA_q;
            lo_d      = '1;
            divZero_d = 1'b1;
          end else begin
            hi_d      = addSum;
            lo_d      = mq_q;
            divZero_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      origA_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      signA_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      carry_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      origA_q   <= origA_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      cnt_q     <= cnt_d;
      signA_q   <= signA_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      carry_q   <= carry_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = divZero_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Testbench for mul_div_seq: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.

module tb_mul_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int total;
  int bad;

  logic [31:0] lastHi;
  logic [31:0] lastLo;
  logic        lastDz;

  mul_div_seq #(.XLEN(32), .ITER_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference results straight from integer arithmetic
  task automatic refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic [63:0] prod;
    longint      sa, sb, q, r;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin
        prod = {32'd0, a} * {32'd0, b};
        h = prod[63:32];
        l = prod[31:0];
      end
      2'b01: begin
        prod = sa * sb;
        h = prod[63:32];
        l = prod[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          dz = 1'b1; h = a; l = 32'hFFFF_FFFF;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; h = a; l = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'd0; l = 32'h8000_0000;
        end else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
    endcase
  endtask

  // Issue one operation, wait for completion and check latency, busy span and results
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b,
                               input bit holdStart);
    logic [31:0] expHi, expLo;
    logic        expDz;
    int          cycles, busyCount;
    refModel(opIn, a, b, expHi, expLo, expDz);
    @(negedge clk);
    start = 1'b1; op = opIn; src_a = a; src_b = b;
    @(posedge clk); #1;
    if (!holdStart) start = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    cycles = 0;
    busyCount = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busyCount++;
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    checkOutput("latency", 64'(cycles), 64'd36);
    checkOutput("busyCycles", 64'(busyCount), 64'd36);
    checkOutput("hi", 64'(hi), 64'(expHi));
    checkOutput("lo", 64'(lo), 64'(expLo));
    checkOutput("div_zero", 64'(div_zero), 64'(expDz));
    @(posedge clk); #1;
    checkOutput("donePulse", 64'(done), 64'd0);
    checkOutput("idleAfter", 64'(busy), 64'd0);
    lastHi = expHi;
    lastLo = expLo;
    lastDz = expDz;
  endtask

  initial begin
    int doneCount;
    logic [1:0]  rOp;
    logic [31:0] rA, rB;
    total = 0;
    bad   = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
    lastHi = '0; lastLo = '0; lastDz = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstHi", 64'(hi), 64'd0);
    checkOutput("rstLo", 64'(lo), 64'd0);
    checkOutput("rstDz", 64'(div_zero), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleBusy", 64'(busy), 64'd0);

    // Directed corner cases; the first holds start high throughout
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(2'b01, 32'hFFFF_FFF9, 32'd3, 1'b0);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus(2'b10, 32'd100, 32'd7, 1'b0);
    applyStimulus(2'b10, 32'd5, 32'd0, 1'b0);
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0);

    // Random operations with occasional zero and extreme operands
    for (int i = 0; i < 24; i++) begin
      rOp = 2'($urandom);
      rA  = $urandom;
      rB  = $urandom;
      case ($urandom_range(0, 7))
        0: rB = 32'd0;
        1: rA = 32'h8000_0000;
        2: rB = 32'($urandom_range(1, 15));
        3: rB = 32'hFFFF_FFFF;
        default: ;
      endcase
      applyStimulus(rOp, rA, rB, 1'b0);
    end

    // Flush at cycle 10 of a multiply: no done, previous results held
    applyStimulus(2'b10, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flushBusy", 64'(busy), 64'd0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneCount++;
    end
    checkOutput("flushNoDone", 64'(doneCount), 64'd0);
    checkOutput("flushHi", 64'(hi), 64'(lastHi));
    checkOutput("flushLo", 64'(lo), 64'(lastLo));
    checkOutput("flushDz", 64'(div_zero), 64'(lastDz));

    // Flush and start together in idle: start is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("flushWinsBusy", 64'(busy), 64'd0);

    // Reset mid-CALC clears everything on the next edge
    applyStimulus(2'b10, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'hFFFF_0000; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstDone", 64'(done), 64'd0);
    checkOutput("midRstHi", 64'(hi), 64'd0);
    checkOutput("midRstLo", 64'(lo), 64'd0);
    checkOutput("midRstDz", 64'(div_zero), 64'd0);
    rst_n = 1'b1;

    // Unit still works after the reset
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
- Iterative 32-bit multiply/divide unit for the ALU.
- Computes MULT, MULTU, DIV and DIVU over a fixed number of cycles.
- Uses exactly one 32-bit carry-lookahead adder instance (FullAdder: a, b, cin → s, cout) for every arithmetic step: operand absolute value, partial-product add, trial subtract and result negation.
- Sits beside the combinational ALU and drives HI/LO results back to the pipeline through a start/busy/done handshake.

Parameters:
- XLEN, 32, operand width (fixed by the adder; other values unsupported)
- ITER_W, 5, iteration counter width (counts 0..XLEN-1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only while busy=0
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- src_a  in  32  multiplicand / dividend; sampled with start
- src_b  in  32  multiplier / divisor; sampled with start
- flush  in  1  abort current operation
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, results valid
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- div_zero  out  1  last DIV/DIVU had divisor 0; valid while done or held

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy, done and div_zero = 0; hi = lo = 0.
  - Counter and internal registers are cleared.
  - Reset overrides everything, including an operation in progress.
- States: IDLE → ABS_A → ABS_B → CALC (32 cycles) → FIX_LO → FIX_HI → IDLE.
  - The path is fixed for all ops, so latency is fixed.
- Start handshake:
  - In IDLE, start=1 latches op, src_a and src_b and moves to ABS_A.
  - start while busy=1 is ignored (not queued).
- busy = 1 in every non-IDLE state, i.e. for exactly 36 cycles.
- done = 1 for exactly one cycle: the first IDLE cycle after FIX_HI (36 edges after the sampling edge).
  - hi, lo and div_zero update on that same edge and hold until the next completed operation.
- ABS_A / ABS_B:
  - Signed ops only: a negative operand is replaced by its two's complement via the adder (a=~x, b=0, cin=1).
  - Otherwise the adder passes the operand through (b=0, cin=0).
  - Record neg_res = sign_a ^ sign_b and neg_rem = sign_a (both 0 for unsigned).
- CALC multiply (shift-add):
  - P = {acc[31:0], mq[31:0]}, acc=0 at entry.
  - Each cycle: sum = mq[0] ? acc+mcand : acc+0.
  - Then {acc, mq} ← {cout, sum, mq[31:1]}.
- CALC divide (restoring):
  - Each cycle: shift {msb, R, Q} left by one.
  - Trial R - d via adder (a=R_shifted, b=~d, cin=1).
  - If cout=1 or msb=1: R ← sum, Q[0]=1; else R is unchanged, Q[0]=0.
- Counter: counts 0..31 in CALC; leaves CALC when counter = 31.
- FIX_LO / FIX_HI (signed ops, when the sign flag requires it):
  - Multiply: negate the 64-bit product.
    - FIX_LO computes ~lo+1 and registers the carry.
    - FIX_HI computes ~hi+carry.
  - Divide:
    - FIX_LO negates the quotient if neg_res.
    - FIX_HI negates the remainder if neg_rem.
  - Otherwise pass-through.
- Divide by zero:
  - div_zero=1; results forced to hi=src_a (original, unmodified) and lo=32'hFFFF_FFFF.
  - Latency is unchanged.
- DIV overflow (-2^31 / -1): lo=32'h8000_0000, hi=0, div_zero=0. No trap.
- flush=1 while busy:
  - Return to IDLE on that edge; busy=0 the next cycle.
  - No done pulse; hi, lo and div_zero keep their previous values.
- flush in IDLE has no effect.
- flush and start in the same IDLE cycle: flush wins, start is dropped.

Test Plan:
- Reset then idle → busy=0, done=0, hi=lo=0; start held while busy never re-triggers.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → done exactly 36 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7×3 (0xFFFFFFF9, 3) → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2.
- DIVU 5/0 → div_zero=1, hi=5, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU started, flush at cycle 10 → busy drops next cycle, no done, hi/lo keep prior result; rst_n=0 mid-CALC → all outputs 0 next cycle.
